// File: rtl/stack_arbiter.sv
// stack_arbiter: shares a DEPTH-level stack between two requesters (req0 = CALL/RET,
// req1 = interrupt save/restore). One transfer per IDLE slot, registered stack strobes,
// occupancy tracking with overflow/underflow blocking and sticky error flags.
// Build option: STACK_ARB_FIXED_PRIO_EN selects fixed priority (req1 wins) instead
// of round-robin arbitration.
module stack_arbiter #(
  parameter int DW    = 18,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_vld,
  input  logic          r0_pop,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_rdy,
  input  logic          r1_vld,
  input  logic          r1_pop,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_rdy,
  output logic          rd_vld,
  output logic          rd_id,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  output logic          stk_we,
  output logic          stk_re,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          err_ovf,
  output logic          err_unf,
  input  logic          err_clr
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POP_WAIT
  } state_e;

  state_e        state_q, state_d;

  logic          stk_we_q, stk_we_d;
  logic          stk_re_q, stk_re_d;
  logic [DW-1:0] stk_din_q, stk_din_d;
  logic          rd_vld_q, rd_vld_d;
  logic          rd_id_q, rd_id_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          own_q, own_d;

  // Grant decode results
  logic          gnt_vld;
  logic          gnt_id;
  logic          gnt_pop;
  logic [DW-1:0] gnt_wdata;
  logic          push_ok;
  logic          push_ovf;
  logic          pop_ok;
  logic          pop_unf;
  logic          is_full;
  logic          is_empty;

`ifndef STACK_ARB_FIXED_PRIO_EN
  // Round-robin pointer: requester preferred when both are valid
  logic          prio_q, prio_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: legal transfers leave IDLE, rejected ones keep the slot free
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (push_ok) begin
          state_d = S_PUSH;
        end else if (pop_ok) begin
          state_d = S_POP;
        end
      end
      S_PUSH:     state_d = S_IDLE;
      S_POP:      state_d = S_POP_WAIT;
      S_POP_WAIT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic: arbitration, handshake and legality of the granted request
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst && (state_q == S_IDLE)) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
      if (r1_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (r0_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
`else
      if (r0_vld && r1_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (r0_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (r1_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
`endif
    end
    r0_rdy    = gnt_vld & ~gnt_id;
    r1_rdy    = gnt_vld &  gnt_id;
    gnt_pop   = gnt_id ? r1_pop   : r0_pop;
    gnt_wdata = gnt_id ? r1_wdata : r0_wdata;
    is_full   = (depth_q == DEPTH_C);
    is_empty  = (depth_q == '0);
    push_ok   = gnt_vld & ~gnt_pop & ~is_full;
    push_ovf  = gnt_vld & ~gnt_pop &  is_full;
    pop_ok    = gnt_vld &  gnt_pop & ~is_empty;
    pop_unf   = gnt_vld &  gnt_pop &  is_empty;
  end

  // Datapath next-state: strobes, occupancy, pop results and sticky errors
  always_comb begin
    stk_we_d  = push_ok;
    stk_re_d  = pop_ok;
    stk_din_d = push_ok ? gnt_wdata : stk_din_q;

    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + ONE_C;
    end else if (pop_ok) begin
      depth_d = depth_q - ONE_C;
    end

    own_d = pop_ok ? gnt_id : own_q;

    rd_vld_d  = 1'b0;
    rd_err_d  = 1'b0;
    rd_id_d   = rd_id_q;
    rd_data_d = rd_data_q;
    if (pop_unf) begin
      // Rejected pop is answered immediately with a zero word flagged as error
      rd_vld_d  = 1'b1;
      rd_err_d  = 1'b1;
      rd_id_d   = gnt_id;
      rd_data_d = '0;
    end else if (state_q == S_POP_WAIT) begin
      rd_vld_d  = 1'b1;
      rd_id_d   = own_q;
      rd_data_d = stk_dout;
    end

    // A new error in the clear cycle keeps the flag set
    err_ovf_d = (err_ovf_q & ~err_clr) | push_ovf;
    err_unf_d = (err_unf_q & ~err_clr) | pop_unf;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_we_q  <= 1'b0;
      stk_re_q  <= 1'b0;
      stk_din_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_id_q   <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      own_q     <= 1'b0;
    end else begin
      stk_we_q  <= stk_we_d;
      stk_re_q  <= stk_re_d;
      stk_din_q <= stk_din_d;
      rd_vld_q  <= rd_vld_d;
      rd_id_q   <= rd_id_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      own_q     <= own_d;
    end
  end

`ifndef STACK_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after any grant, prefer the other requester
  always_comb begin
    prio_d = gnt_vld ? ~gnt_id : prio_q;
  end

  // Round-robin pointer register, starts preferring req0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  assign stk_we  = stk_we_q;
  assign stk_re  = stk_re_q;
  assign stk_din = stk_din_q;
  assign rd_vld  = rd_vld_q;
  assign rd_id   = rd_id_q;
  assign rd_data = rd_data_q;
  assign rd_err  = rd_err_q;
  assign depth   = depth_q;
  assign full    = is_full;
  assign empty   = is_empty;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule
